// File: rtl/instr_fetch.sv
// Fetch stage: issues program-memory reads at the Program_Counter's PC and hands
// {instruction, PC} to decode through a small buffer with redirect/halt flushing.
module instr_fetch #(
    parameter int INSTR_WIDTH = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  pc_in,
    output logic                   pc_halt,
    output logic                   pc_load_en,
    output logic [ADDR_WIDTH-1:0]  pc_load_val,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic                   imem_rd_en,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   redirect_req,
    input  logic [ADDR_WIDTH-1:0]  redirect_addr,
    input  logic                   halt_req,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic                   halted
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {RUN, HALTED} state_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       count;
    logic [PTR_W-1:0]       head, tail;
    logic                   vld_p1;
    logic [ADDR_WIDTH-1:0]  pc_p1;
    logic [INSTR_WIDTH-1:0] buf_data [DEPTH];
    logic [ADDR_WIDTH-1:0]  buf_pc   [DEPTH];

    logic                   active, halt_go, redir_go, flush;
    logic                   pop, push, issue;
    logic [CNT_W:0]         occ;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        active    = 1'b0;
        halt_go   = 1'b0;
        redir_go  = 1'b0;
        flush     = 1'b0;
        pop       = 1'b0;
        push      = 1'b0;
        occ       = '0;
        issue     = 1'b0;
        state_nxt = state;

        // Reset held low blocks issue/load combinationally, not just at the edge
        active   = reset && (state == RUN);
        halt_go  = active && halt_req;
        redir_go = active && redirect_req && !halt_req;
        flush    = halt_go || redir_go;
        pop      = instr_valid && instr_ready;
        push     = vld_p1 && !flush;
        // Occupancy after this cycle's pop, counting the read still in flight
        occ      = {1'b0, count} + {{CNT_W{1'b0}}, vld_p1} - {{CNT_W{1'b0}}, pop};
        issue    = active && !halt_req && !redirect_req && (occ < (CNT_W + 1)'(DEPTH));

        if (halt_go) begin
            state_nxt = HALTED;
        end
    end

    assign imem_addr   = pc_in;
    assign imem_rd_en  = issue;
    assign pc_load_en  = redir_go;
    assign pc_load_val = redirect_addr;
    assign pc_halt     = !issue && !redir_go;
    assign instr_valid = reset && (count != '0);
    assign instr_data  = buf_data[head];
    assign instr_pc    = buf_pc[head];
    assign halted      = reset && (state == HALTED);

    // p0 -> p1: read issue; p1 -> buffer: read return
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= RUN;
            vld_p1 <= 1'b0;
            count  <= '0;
            head   <= '0;
            tail   <= '0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= issue;
            if (flush) begin
                count <= '0;
                head  <= '0;
                tail  <= '0;
            end else begin
                if (push) tail <= ptr_inc(tail);
                if (pop)  head <= ptr_inc(head);
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            pc_p1 <= pc_in;
        end
        if (push) begin
            buf_data[tail] <= imem_rdata;
            buf_pc[tail]   <= pc_p1;
        end
    end

endmodule
